// File: rtl/icetap_pkg.sv
// Shared definitions for the icetap capture/readout blocks: FSM encodings,
// frame constants and width helpers.
package icetap_pkg;

    localparam logic [2:0] RD_IDLE  = 3'd0;
    localparam logic [2:0] RD_HDR   = 3'd1;
    localparam logic [2:0] RD_SEND  = 3'd2;
    localparam logic [2:0] RD_FETCH = 3'd3;
    localparam logic [2:0] RD_LOAD  = 3'd4;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Capture FSM encodings, kept here so both clock domains agree on them.
    localparam logic [1:0] CAP_IDLE      = 2'd0;
    localparam logic [1:0] CAP_ARMED     = 2'd1;
    localparam logic [1:0] CAP_TRIGGERED = 2'd2;
    localparam logic [1:0] CAP_DONE      = 2'd3;

    function automatic int idx_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/icetap_sync2.sv
// Two-flop synchronizer for a single level signal crossing into scan_clk.
module icetap_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/icetap_readout.sv
// Readout engine: walks the capture RAM from start to stop and streams a framed
// byte sequence (sync, trigger offset, count-1, samples) over valid/ready.
module icetap_readout
    import icetap_pkg::*;
#(
    parameter int NR_SIGNALS       = 16,
    parameter int RECORD_DEPTH     = 256,
    parameter int RAM_ADDR_BITS    = $clog2(RECORD_DEPTH),
    parameter int BYTES_PER_SAMPLE = bytes_for(NR_SIGNALS),
    parameter int ADDR_BYTES       = bytes_for(RAM_ADDR_BITS)
) (
    input  logic                     scan_clk,
    input  logic                     scan_reset_,
    input  logic                     dump_req,
    input  logic                     capture_idle,
    input  logic [RAM_ADDR_BITS-1:0] start_addr,
    input  logic [RAM_ADDR_BITS-1:0] trigger_addr,
    input  logic [RAM_ADDR_BITS-1:0] stop_addr,
    output logic [RAM_ADDR_BITS-1:0] mem_rd_addr,
    input  logic [NR_SIGNALS-1:0]    mem_rd_data,
    output logic                     busy,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [7:0]               tx_data
);

    localparam int SR_W   = BYTES_PER_SAMPLE * 8;
    localparam int HB_W   = ADDR_BYTES * 8;
    localparam int BIDX_W = idx_bits(BYTES_PER_SAMPLE);
    localparam int HIDX_W = idx_bits(2 * ADDR_BYTES + 1);
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;

    logic                     idle_sync;
    logic [2:0]               state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic [SR_W-1:0]          shift_q, shift_d;
    logic [2*HB_W-1:0]        hdr_q, hdr_d;
    logic [HIDX_W-1:0]        hdr_idx_q, hdr_idx_d;
    logic [BIDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic [RAM_ADDR_BITS-1:0] smp_idx_q, smp_idx_d;
    logic [RAM_ADDR_BITS-1:0] cnt_m1_q, cnt_m1_d;
    logic [1:0]               fetch_ph_q, fetch_ph_d;

    logic [RAM_ADDR_BITS-1:0] ofs_w;
    logic [RAM_ADDR_BITS-1:0] cnt_m1_w;
    logic [SR_W-1:0]          smp_ext;
    logic [SR_W-1:0]          shift_nxt;
    logic [2*HB_W-1:0]        hdr_nxt;
    logic                     xfer;

    icetap_sync2 u_idle_sync (
        .clk   (scan_clk),
        .rst_n (scan_reset_),
        .d     (capture_idle),
        .q     (idle_sync)
    );

    // Modulo arithmetic falls out of the fixed address width; CNT=0 wraps to DEPTH-1.
    assign ofs_w     = trigger_addr - start_addr;
    assign cnt_m1_w  = stop_addr - start_addr - ADDR_ONE;
    assign smp_ext   = SR_W'(mem_rd_data);
    assign shift_nxt = shift_q >> 8;
    assign hdr_nxt   = hdr_q >> 8;
    assign xfer      = tx_valid_q && tx_ready;

    always_comb begin
        state_d       = state_q;
        mem_rd_addr_d = mem_rd_addr_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        shift_d       = shift_q;
        hdr_d         = hdr_q;
        hdr_idx_d     = hdr_idx_q;
        byte_idx_d    = byte_idx_q;
        smp_idx_d     = smp_idx_q;
        cnt_m1_d      = cnt_m1_q;
        fetch_ph_d    = fetch_ph_q;
        case (state_q)
            RD_IDLE: begin
                if (dump_req && idle_sync) begin
                    state_d       = RD_HDR;
                    mem_rd_addr_d = start_addr;
                    cnt_m1_d      = cnt_m1_w;
                    hdr_d         = {HB_W'(cnt_m1_w), HB_W'(ofs_w)};
                    hdr_idx_d     = '0;
                    byte_idx_d    = '0;
                    smp_idx_d     = '0;
                    fetch_ph_d    = 2'd1;
                    tx_valid_d    = 1'b1;
                    tx_data_d     = SYNC_BYTE;
                end
            end
            RD_HDR: begin
                // Sample 0 arrives two cycles into the header, well before it is needed.
                if (fetch_ph_q == 2'd1) begin
                    fetch_ph_d = 2'd2;
                end else if (fetch_ph_q == 2'd2) begin
                    shift_d    = smp_ext;
                    fetch_ph_d = 2'd0;
                end
                if (xfer) begin
                    if (hdr_idx_q == HIDX_W'(2 * ADDR_BYTES)) begin
                        state_d   = RD_SEND;
                        tx_data_d = shift_q[7:0];
                    end else begin
                        tx_data_d = hdr_q[7:0];
                        hdr_d     = hdr_nxt;
                        hdr_idx_d = hdr_idx_q + 1'b1;
                    end
                end
            end
            RD_SEND: begin
                if (xfer) begin
                    if (byte_idx_q == BIDX_W'(BYTES_PER_SAMPLE - 1)) begin
                        tx_valid_d = 1'b0;
                        byte_idx_d = '0;
                        if (smp_idx_q == cnt_m1_q) begin
                            state_d = RD_IDLE;
                        end else begin
                            state_d       = RD_FETCH;
                            mem_rd_addr_d = mem_rd_addr_q + ADDR_ONE;
                            smp_idx_d     = smp_idx_q + ADDR_ONE;
                        end
                    end else begin
                        shift_d    = shift_nxt;
                        tx_data_d  = shift_nxt[7:0];
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            RD_FETCH: begin
                state_d = RD_LOAD;
            end
            RD_LOAD: begin
                state_d    = RD_SEND;
                shift_d    = smp_ext;
                tx_data_d  = smp_ext[7:0];
                tx_valid_d = 1'b1;
            end
            default: begin
                state_d    = RD_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge scan_clk or negedge scan_reset_) begin
        if (!scan_reset_) begin
            state_q       <= RD_IDLE;
            mem_rd_addr_q <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            shift_q       <= '0;
            hdr_q         <= '0;
            hdr_idx_q     <= '0;
            byte_idx_q    <= '0;
            smp_idx_q     <= '0;
            cnt_m1_q      <= '0;
            fetch_ph_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            shift_q       <= shift_d;
            hdr_q         <= hdr_d;
            hdr_idx_q     <= hdr_idx_d;
            byte_idx_q    <= byte_idx_d;
            smp_idx_q     <= smp_idx_d;
            cnt_m1_q      <= cnt_m1_d;
            fetch_ph_q    <= fetch_ph_d;
        end
    end

    assign busy        = (state_q != RD_IDLE);
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign mem_rd_addr = mem_rd_addr_q;

endmodule

// File: tb/tb_icetap_readout.sv
// Bench for icetap_readout: directed frames from the test plan plus random
// pointer/backpressure frames, checked against a frame model built from the rules.
module tb_icetap_readout;

    localparam int NS    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          scan_clk = 1'b0;
    logic          scan_reset_;
    logic          dump_req;
    logic          capture_idle;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] trigger_addr;
    logic [AW-1:0] stop_addr;
    logic [AW-1:0] mem_rd_addr;
    logic [NS-1:0] mem_rd_data;
    logic          busy;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;

    logic [NS-1:0] mem [DEPTH];
    logic [7:0]    got [$];
    logic [7:0]    exp_q [$];
    int            exp_cycles;
    int            checks;
    int            errors;

    logic stall;
    logic rand_mode;
    logic rnd_bit = 1'b1;
    logic prev_stall;
    logic [7:0] prev_data;

    icetap_readout #(
        .NR_SIGNALS   (NS),
        .RECORD_DEPTH (DEPTH)
    ) dut (
        .scan_clk     (scan_clk),
        .scan_reset_  (scan_reset_),
        .dump_req     (dump_req),
        .capture_idle (capture_idle),
        .start_addr   (start_addr),
        .trigger_addr (trigger_addr),
        .stop_addr    (stop_addr),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .busy         (busy),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data)
    );

    always #5 scan_clk = ~scan_clk;

    always @(posedge scan_clk) mem_rd_data <= mem[mem_rd_addr];

    assign tx_ready = rnd_bit & ~stall;

    always @(negedge scan_clk) rnd_bit = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Byte collector plus hold-while-stalled check on every cycle.
    always @(posedge scan_clk) begin
        if (scan_reset_) begin
            if (prev_stall) begin
                checkOutput("hold_valid", {31'd0, tx_valid}, 32'd1);
                checkOutput("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic buildExpected(input int s, input int t, input int p);
        int ofs, cnt, a, v;
        exp_q.delete();
        ofs = (t - s + DEPTH) % DEPTH;
        cnt = (p - s + DEPTH) % DEPTH;
        if (cnt == 0) cnt = DEPTH;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(ofs));
        exp_q.push_back(8'(cnt - 1));
        for (int k = 0; k < cnt; k++) begin
            a = (s + k) % DEPTH;
            v = 32'h1100 + a;
            exp_q.push_back(8'(v & 8'hFF));
            exp_q.push_back(8'(v >> 8));
        end
        exp_cycles = 3 + cnt * 2 + 2 * (cnt - 1);
    endtask

    task automatic applyStimulus(input int s, input int t, input int p);
        @(negedge scan_clk);
        start_addr   = AW'(s);
        trigger_addr = AW'(t);
        stop_addr    = AW'(p);
        dump_req     = 1'b1;
        @(posedge scan_clk);
        #1 dump_req = 1'b0;
    endtask

    task automatic waitDone(output int n);
        int guard;
        n = 1;
        guard = 0;
        while (busy && guard < 5000) begin
            @(posedge scan_clk);
            #1;
            guard++;
            if (busy) n++;
        end
        if (guard >= 5000) checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
        checkOutput("end_valid", {31'd0, tx_valid}, 32'd0);
    endtask

    task automatic compareFrame(input string tag);
        int m;
        checkOutput({tag, "_len"}, got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic runFrame(input string tag, input int s, input int t, input int p,
                            input bit do_stall, input bit check_cycles);
        int n;
        buildExpected(s, t, p);
        got.delete();
        applyStimulus(s, t, p);
        checkOutput({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_first"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
        if (do_stall) begin
            n = 0;
            while (got.size() < 3 && n < 100) begin
                @(posedge scan_clk);
                #1 n++;
            end
            stall = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge scan_clk);
                #1;
                checkOutput("stall_valid", {31'd0, tx_valid}, 32'd1);
                checkOutput("stall_data", {24'd0, tx_data}, 32'h00);
                checkOutput("stall_addr", {28'd0, mem_rd_addr}, s);
            end
            stall = 1'b0;
        end
        waitDone(n);
        if (check_cycles) checkOutput({tag, "_cycles"}, n, exp_cycles);
        compareFrame(tag);
    endtask

    initial begin
        int n;
        checks       = 0;
        errors       = 0;
        scan_reset_  = 1'b0;
        dump_req     = 1'b0;
        capture_idle = 1'b1;
        start_addr   = '0;
        trigger_addr = '0;
        stop_addr    = '0;
        stall        = 1'b0;
        rand_mode    = 1'b0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = NS'(16'h1100 + i);

        #2;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_addr", {28'd0, mem_rd_addr}, 32'd0);
        #20;
        @(negedge scan_clk) scan_reset_ = 1'b1;
        repeat (3) @(posedge scan_clk);

        runFrame("full", 0, 8, 0, 1'b0, 1'b1);
        runFrame("wrap", 5, 13, 5, 1'b0, 1'b1);
        runFrame("partial", 0, 3, 11, 1'b0, 1'b1);
        checkOutput("partial_total", exp_q.size(), 25);
        runFrame("bp", 0, 8, 0, 1'b1, 1'b0);

        // Request while capture is not idle must be dropped.
        capture_idle = 1'b0;
        repeat (3) @(posedge scan_clk);
        got.delete();
        applyStimulus(0, 8, 0);
        checkOutput("rej_idle_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(posedge scan_clk);
        #1;
        checkOutput("rej_idle_busy_late", {31'd0, busy}, 32'd0);
        checkOutput("rej_idle_bytes", got.size(), 0);
        capture_idle = 1'b1;
        repeat (3) @(posedge scan_clk);

        // Request mid-frame with different pointers must be ignored.
        buildExpected(0, 8, 0);
        got.delete();
        applyStimulus(0, 8, 0);
        repeat (8) @(posedge scan_clk);
        applyStimulus(3, 1, 7);
        waitDone(n);
        compareFrame("rej_mid");
        repeat (20) @(posedge scan_clk);
        #1;
        checkOutput("rej_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rej_mid_bytes", got.size(), exp_q.size());

        // Asynchronous reset in the middle of a sample.
        got.delete();
        applyStimulus(0, 8, 0);
        n = 0;
        while (got.size() < 10 && n < 200) begin
            @(posedge scan_clk);
            #1 n++;
        end
        checkOutput("pre_rst_addr_nz", {31'd0, (mem_rd_addr != 0)}, 32'd1);
        @(negedge scan_clk);
        #2 scan_reset_ = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_addr", {28'd0, mem_rd_addr}, 32'd0);
        checkOutput("mid_rst_data", {24'd0, tx_data}, 32'd0);
        @(negedge scan_clk) scan_reset_ = 1'b1;
        repeat (3) @(posedge scan_clk);
        runFrame("post_rst", 0, 8, 0, 1'b0, 1'b1);

        // Random pointers with random backpressure.
        @(posedge scan_clk);
        #1 rand_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            runFrame($sformatf("rnd%0d", r), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1'b0, 1'b0);
        end
        rand_mode = 1'b0;
        repeat (3) @(posedge scan_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
